// File: rtl/mem_access_pkg.sv
// Shared constants, decode enums and lane helpers for the data-memory access sequencer.
package mem_access_pkg;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;

  typedef enum logic [2:0] {
    LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3, LBU = 3'd4, LHU = 3'd5, LWU = 3'd6
  } load_f3_t;

  typedef enum logic [2:0] {
    SB = 3'd0, SH = 3'd1, SW = 3'd2, SD = 3'd3
  } store_f3_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mac_state_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Bytes shifted past bit 63 fall off, so a lane crossing the doubleword is truncated.
  function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] wd,
                                              input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] lane_mask;
    logic [63:0] mask;
    logic [5:0]  sh;
    case (f3[1:0])
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
    sh   = {off, 3'b000};
    mask = lane_mask << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load lane extraction: shift the doubleword down by the byte offset, then sign/zero extend.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] lane;

  assign lane = data >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      LB:      result = {{56{lane[7]}},  lane[7:0]};
      LH:      result = {{48{lane[15]}}, lane[15:0]};
      LW:      result = {{32{lane[31]}}, lane[31:0]};
      LBU:     result = {56'd0, lane[7:0]};
      LHU:     result = {48'd0, lane[15:0]};
      LWU:     result = {32'd0, lane[31:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the 64-bit data memory port; sub-doubleword stores use read-modify-write.
// Define MEM_ACCESS_MISALIGN_TRAP_EN to reject misaligned accesses with err instead of truncating.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  mac_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       addr_q, wdata_q, load_value;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic              is_load, is_store, is_sd, trap;
  logic              unused_instr_bits;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE) && !f3[2];
  assign is_sd    = is_store && (f3[1:0] == 2'b11);
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic err_q;

  assign trap = (is_load || is_store) && misaligned(addr[2:0], f3);
  assign err  = (state == DONE) && err_q;

  always_ff @(posedge clk) begin
    if (reset)                         err_q <= 1'b0;
    else if (state == IDLE && start)   err_q <= trap;
  end
`else
  assign trap = 1'b0;
  assign err  = 1'b0;
`endif

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign mem_wr   = (state == WRITE);
  assign mem_addr = {addr_q[63:3], 3'b000};

  load_extend u_load_extend (
    .data   (mem_rdata),
    .offset (addr_q[2:0]),
    .funct3 (f3_q),
    .result (load_value)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (trap)                         state_nxt = DONE;
          else if (is_sd)                   state_nxt = WRITE;
          else if (is_load || is_store)     state_nxt = READ;
          else                              state_nxt = DONE;
        end
      end
      READ:    if (cnt == '0) state_nxt = store_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      rdata     <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= f3;
            store_q <= is_store;
            cnt     <= CNT_W'(MEM_LAT - 1);
            if (is_sd && !trap) mem_wdata <= wdata;
          end
        end
        READ: begin
          if (cnt != '0)    cnt       <= cnt - 1'b1;
          else if (store_q) mem_wdata <= store_merge(mem_rdata, wdata_q, addr_q[2:0], f3_q);
          else              rdata     <= load_value;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: two instances (MEM_LAT 1 and 3), directed vector table, reset corner, random ops vs model.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    int          done_cyc;
    logic        err;
    int          wr_cyc;
    logic [63:0] wr_data;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    int          done_cyc;
    logic        err;
    int          wr_cnt;
    int          wr_cyc;
    logic [63:0] wr_data;
    logic [63:0] rdata;
    logic        addr_bad;
    logic        busy_after;
  } res_t;

  typedef struct {
    int          inst;
    logic [31:0] ins;
    logic [63:0] a;
    logic [63:0] wd;
    bit          spam;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic [31:0] instr [2];
  logic [63:0] addr [2], wdata [2];
  logic        busy [2], done [2], err [2], mem_wr [2];
  logic [63:0] rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [63:0] mem [2][16];
  logic [63:0] ref_mem [2][16];
  logic [63:0] ref_rdata [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    int          run    = 0;
    logic [63:0] last_a = '0;
    logic        rd_ok;

    mem_access_ctrl #(.MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start[g]),
      .instr     (instr[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .err       (err[g]),
      .rdata     (rdata[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wr    (mem_wr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Memory model: data is only valid after LAT consecutive stable read cycles.
    always @(posedge clk) begin
      if (busy[g] && !mem_wr[g])
        run <= (run > 0 && mem_addr[g] == last_a) ? run + 1 : 1;
      else
        run <= 0;
      last_a <= mem_addr[g];
    end

    assign rd_ok = busy[g] && !mem_wr[g] &&
                   ((run == 0) ? (LAT == 1) : (mem_addr[g] == last_a && run + 1 >= LAT));
    assign mem_rdata[g] = rd_ok ? mem[g][mem_addr[g][6:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mk(input int op, input int f3);
    logic [6:0] o7;
    logic [2:0] f;
    o7 = op[6:0];
    f  = f3[2:0];
    return {17'd0, f, 5'd0, o7};
  endfunction

  // Reference model working on byte arrays from the access rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] wd,
                                 input logic [63:0] word, input logic [63:0] old_rdata, input int lat);
    exp_t        e;
    int          op, f3, o, n;
    logic [7:0]  mb [8];
    logic [7:0]  wb [8];
    logic [63:0] v;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    o  = int'(a[2:0]);
    n  = 1 << (f3 % 4);
    e.done_cyc = 1; e.err = 1'b0; e.wr_cyc = 0; e.wr_data = '0; e.rdata = old_rdata;
    if (!(op == 3 || (op == 35 && f3 < 4))) return e;
    if (TRAP && (o % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    for (int k = 0; k < 8; k++) begin
      mb[k] = word[8*k +: 8];
      wb[k] = wd[8*k +: 8];
    end
    if (op == 3) begin
      v = '0;
      for (int k = 0; k < n; k++)
        if (o + k < 8) v[8*k +: 8] = mb[o+k];
      if (f3 < 4 && n < 8 && v[8*n-1])
        for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
      e.rdata    = v;
      e.done_cyc = lat + 1;
    end else if (n == 8) begin
      e.wr_cyc = 1; e.wr_data = wd; e.done_cyc = 2;
    end else begin
      for (int k = 0; k < n; k++)
        if (o + k < 8) mb[o+k] = wb[k];
      for (int k = 0; k < 8; k++) e.wr_data[8*k +: 8] = mb[k];
      e.wr_cyc = lat + 1; e.done_cyc = lat + 2;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input int i, input logic [31:0] ins, input logic [63:0] a,
                        input logic [63:0] wd, input bit spam, output res_t r);
    r.done_cyc = -1; r.err = 1'b0; r.wr_cnt = 0; r.wr_cyc = 0; r.wr_data = '0;
    r.rdata = '0; r.addr_bad = 1'b0; r.busy_after = 1'b0;
    @(negedge clk);
    start[i] = 1'b1; instr[i] = ins; addr[i] = a; wdata[i] = wd;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (spam) begin
        start[i] = 1'b1; instr[i] = mk(3, 3); addr[i] = a ^ 64'h8;
      end else begin
        start[i] = 1'b0;
      end
      if (mem_wr[i]) begin
        r.wr_cnt++; r.wr_cyc = c; r.wr_data = mem_wdata[i];
        mem[i][mem_addr[i][6:3]] = mem_wdata[i];
      end
      if (busy[i] && !done[i] && mem_addr[i] !== {a[63:3], 3'b000}) r.addr_bad = 1'b1;
      r.rdata = rdata[i];
      if (done[i]) begin
        r.done_cyc = c; r.err = err[i];
        break;
      end
    end
    start[i] = 1'b0;
    @(negedge clk);
    r.busy_after = busy[i] | mem_wr[i];
  endtask

  task automatic check_run(input string tag, input res_t r, input exp_t e);
    check({tag, " done_cycle"}, 64'(r.done_cyc), 64'(e.done_cyc));
    check({tag, " err"},        64'(r.err),      64'(e.err));
    check({tag, " rdata"},      r.rdata,         e.rdata);
    check({tag, " wr_count"},   64'(r.wr_cnt),   64'(e.wr_cyc != 0));
    if (e.wr_cyc != 0) begin
      check({tag, " wr_cycle"}, 64'(r.wr_cyc),   64'(e.wr_cyc));
      check({tag, " wr_data"},  r.wr_data,       e.wr_data);
    end
    check({tag, " addr_stable"}, 64'(r.addr_bad),   64'd0);
    check({tag, " idle_after"},  64'(r.busy_after), 64'd0);
  endtask

  localparam logic [63:0] DW = 64'h8877_6655_4433_2211;

  initial begin
    vec_t vt [13];
    res_t r;
    exp_t e;
    int   wr_seen;

    vt[0]  = '{0, mk(3, 0),  64'h107, 64'h0, 1'b0, '{2, 1'b0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FF88}};
    vt[1]  = '{0, mk(3, 5),  64'h106, 64'h0, 1'b0, '{2, 1'b0, 0, 64'h0, 64'h0000_0000_0000_8877}};
    vt[2]  = '{0, mk(3, 2),  64'h104, 64'h0, 1'b0, '{2, 1'b0, 0, 64'h0, 64'hFFFF_FFFF_8877_6655}};
    vt[3]  = '{0, mk(3, 6),  64'h104, 64'h0, 1'b0, '{2, 1'b0, 0, 64'h0, 64'h0000_0000_8877_6655}};
    vt[4]  = '{0, mk(51, 0), 64'h100, 64'h5, 1'b0, '{1, 1'b0, 0, 64'h0, 64'h0000_0000_8877_6655}};
    vt[5]  = '{0, mk(35, 4), 64'h100, 64'h1234, 1'b0, '{1, 1'b0, 0, 64'h0, 64'h0000_0000_8877_6655}};
    vt[6]  = '{0, mk(35, 0), 64'h102, 64'hAB, 1'b0,
               '{3, 1'b0, 2, 64'h8877_6655_44AB_2211, 64'h0000_0000_8877_6655}};
    vt[7]  = '{0, mk(35, 3), 64'h100, 64'h0123_4567_89AB_CDEF, 1'b0,
               '{2, 1'b0, 1, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_8877_6655}};
    if (TRAP) begin
      vt[8] = '{0, mk(35, 1), 64'h103, 64'hCDEF, 1'b0, '{1, 1'b1, 0, 64'h0, 64'h0000_0000_8877_6655}};
      vt[9] = '{0, mk(3, 2),  64'h105, 64'h0,    1'b0, '{1, 1'b1, 0, 64'h0, 64'h0000_0000_8877_6655}};
    end else begin
      vt[8] = '{0, mk(35, 1), 64'h103, 64'hCDEF, 1'b0,
                '{3, 1'b0, 2, 64'h8877_66CD_EF33_2211, 64'h0000_0000_8877_6655}};
      vt[9] = '{0, mk(3, 2),  64'h105, 64'h0,    1'b0, '{2, 1'b0, 0, 64'h0, 64'h0000_0000_0088_7766}};
    end
    vt[10] = '{1, mk(3, 3),  64'h100, 64'h0, 1'b1, '{4, 1'b0, 0, 64'h0, DW}};
    vt[11] = '{1, mk(3, 0),  64'h101, 64'h0, 1'b0, '{4, 1'b0, 0, 64'h0, 64'h22}};
    vt[12] = '{1, mk(35, 2), 64'h104, 64'hDEAD_BEEF, 1'b0,
               '{5, 1'b0, 4, 64'hDEAD_BEEF_4433_2211, 64'h22}};

    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; instr[i] = '0; addr[i] = '0; wdata[i] = '0;
      for (int k = 0; k < 16; k++) mem[i][k] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d busy", i),      64'(busy[i]),   64'd0);
      check($sformatf("reset%0d done", i),      64'(done[i]),   64'd0);
      check($sformatf("reset%0d err", i),       64'(err[i]),    64'd0);
      check($sformatf("reset%0d rdata", i),     rdata[i],       64'd0);
      check($sformatf("reset%0d mem_wr", i),    64'(mem_wr[i]), 64'd0);
      check($sformatf("reset%0d mem_addr", i),  mem_addr[i],    64'd0);
      check($sformatf("reset%0d mem_wdata", i), mem_wdata[i],   64'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 13; v++) begin
      mem[vt[v].inst][0] = DW;
      run_op(vt[v].inst, vt[v].ins, vt[v].a, vt[v].wd, vt[v].spam, r);
      check_run($sformatf("vec%0d", v), r, vt[v].e);
    end

    // Reset during the READ cycle of an sw: no write may ever follow and rdata clears.
    mem[0][0] = DW;
    @(negedge clk);
    start[0] = 1'b1; instr[0] = mk(35, 2); addr[0] = 64'h104; wdata[0] = 64'h1111_2222;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    check("midreset in_read busy", 64'(busy[0]), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy",      64'(busy[0]), 64'd0);
    check("midreset rdata",     rdata[0],     64'd0);
    check("midreset mem_addr",  mem_addr[0],  64'd0);
    check("midreset mem_wdata", mem_wdata[0], 64'd0);
    wr_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_wr[0]) wr_seen++;
      @(negedge clk);
    end
    check("midreset no_write", 64'(wr_seen), 64'd0);

    for (int i = 0; i < 2; i++) begin
      ref_rdata[i] = '0;
      for (int k = 0; k < 16; k++) begin
        mem[i][k]     = {$urandom, $urandom};
        ref_mem[i][k] = mem[i][k];
      end
    end
    for (int t = 0; t < 160; t++) begin
      int          i, sel, op;
      logic [63:0] a, wd;
      bit          spam;
      i   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 3 : (sel < 8) ? 35 : (sel == 8) ? 51 : $urandom_range(0, 127);
      a   = {$urandom, $urandom};
      wd  = {$urandom, $urandom};
      spam = ($urandom_range(0, 3) == 0);
      e = model(mk(op, $urandom_range(0, 7)), a, wd, ref_mem[i][a[6:3]], ref_rdata[i], lat_of(i));
      instr[i] = '0;
      run_op(i, mk(op, 0) | e.done_cyc * 0 | 32'h0, a, wd, 1'b0, r) ;
      check_run($sformatf("rand%0d", t), r, model(mk(op, 0), a, wd, ref_mem[i][a[6:3]],
                ref_rdata[i], lat_of(i)));
      e = model(mk(op, 0), a, wd, ref_mem[i][a[6:3]], ref_rdata[i], lat_of(i));
      ref_rdata[i] = e.rdata;
      if (e.wr_cyc != 0) ref_mem[i][a[6:3]] = e.wr_data;
      begin
        logic [31:0] ins2;
        ins2 = mk(op, $urandom_range(0, 7));
        e = model(ins2, a, wd, ref_mem[i][a[6:3]], ref_rdata[i], lat_of(i));
        run_op(i, ins2, a, wd, spam, r);
        check_run($sformatf("rand%0d_f3", t), r, e);
        ref_rdata[i] = e.rdata;
        if (e.wr_cyc != 0) ref_mem[i][a[6:3]] = e.wr_data;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
